// File: rtl/mips_pkg.sv
// mips_pkg: constants and the IF/ID register layout shared by the pipeline stages
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0] pc4;
    logic valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/redirect controls, instruction memory and IF/ID outputs of the fetch stage
interface fetch_stage_if #(parameter int CNT_W = 16);
  import mips_pkg::*;
  logic PCwrite;
  logic IFIDwrite;
  logic redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic ifid_valid;
  logic misalign_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master(
    output PCwrite, IFIDwrite, redirect, redirect_target, imem_rdata,
    input imem_addr, ifid_instr, ifid_pc4, ifid_valid, misalign_err, stall_cnt, flush_cnt
  );
  modport slave(
    input PCwrite, IFIDwrite, redirect, redirect_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, misalign_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// sat_counter: event counter that sticks at its maximum value
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register of the 5-stage MIPS pipeline
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.slave bus
);
  import mips_pkg::ifid_t;
  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  ifid_t       r_ifid;
  logic        r_misalign;
  assign w_pc4 = r_pc + 32'd4;
  // redirect beats both stall controls: the ID instruction is younger than the branch
  always_ff @(posedge clk)
    if (rst) begin
      r_pc       <= RESET_PC;
      r_ifid     <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      r_misalign <= 1'b0;
    end else begin
      r_pc <= bus.redirect ? {bus.redirect_target[31:2], 2'b00} : bus.PCwrite ? w_pc4 : r_pc;
      if (bus.redirect) r_ifid <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      else if (bus.IFIDwrite) r_ifid <= '{instr: bus.imem_rdata, pc4: w_pc4, valid: 1'b1};
      if (bus.redirect && |bus.redirect_target[1:0]) r_misalign <= 1'b1;
    end
  assign bus.imem_addr    = r_pc;
  assign bus.ifid_instr   = r_ifid.instr;
  assign bus.ifid_pc4     = r_ifid.pc4;
  assign bus.ifid_valid   = r_ifid.valid;
  assign bus.misalign_err = r_misalign;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(!bus.PCwrite && !bus.redirect), .count(bus.stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(bus.redirect), .count(bus.flush_cnt)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors on a default fetch stage and a small-counter, high-reset-PC one
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst0, rst1;
  int n_err = 0;
  int n_chk = 0;
  always #5 clk = ~clk;
  fetch_stage_if #(.CNT_W(16)) b0();
  fetch_stage_if #(.CNT_W(3))  b1();
  assign b0.imem_rdata = b0.imem_addr ^ 32'hA5A5_0000;
  assign b1.imem_rdata = b1.imem_addr ^ 32'hA5A5_0000;
  fetch_stage u0 (.clk(clk), .rst(rst0), .bus(b0));
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) u1 (.clk(clk), .rst(rst1), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.PCwrite = 1'b1; b0.IFIDwrite = 1'b1; b0.redirect = 1'b0; b0.redirect_target = '0;
    b1.PCwrite = 1'b1; b1.IFIDwrite = 1'b1; b1.redirect = 1'b0; b1.redirect_target = '0;
    step();
    chk("rst_pc", b0.imem_addr, 32'h0);
    chk("rst_instr", b0.ifid_instr, 32'h0);
    chk("rst_pc4", b0.ifid_pc4, 32'h0);
    chk("rst_valid", {31'b0, b0.ifid_valid}, 32'h0);
    chk("rst_mis", {31'b0, b0.misalign_err}, 32'h0);
    chk("rst_stall", {16'b0, b0.stall_cnt}, 32'h0);
    chk("rst_flush", {16'b0, b0.flush_cnt}, 32'h0);
    rst0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("run_pc", b0.imem_addr, 32'(4 * k));
      chk("run_instr", b0.ifid_instr, 32'(4 * (k - 1)) ^ 32'hA5A5_0000);
      chk("run_pc4", b0.ifid_pc4, 32'(4 * k));
      chk("run_valid", {31'b0, b0.ifid_valid}, 32'h1);
    end
    b0.PCwrite = 1'b0; b0.IFIDwrite = 1'b0;
    step();
    chk("stall_pc", b0.imem_addr, 32'h10);
    chk("stall_instr", b0.ifid_instr, 32'hA5A5_000C);
    chk("stall_pc4", b0.ifid_pc4, 32'h10);
    chk("stall_cnt", {16'b0, b0.stall_cnt}, 32'h1);
    b0.PCwrite = 1'b1; b0.IFIDwrite = 1'b1;
    step();
    chk("resume_pc", b0.imem_addr, 32'h14);
    chk("resume_instr", b0.ifid_instr, 32'hA5A5_0010);
    chk("resume_pc4", b0.ifid_pc4, 32'h14);
    b0.PCwrite = 1'b0; b0.IFIDwrite = 1'b0; b0.redirect = 1'b1; b0.redirect_target = 32'h400;
    step();
    chk("flush_pc", b0.imem_addr, 32'h400);
    chk("flush_instr", b0.ifid_instr, 32'h0);
    chk("flush_pc4", b0.ifid_pc4, 32'h0);
    chk("flush_valid", {31'b0, b0.ifid_valid}, 32'h0);
    chk("flush_cnt", {16'b0, b0.flush_cnt}, 32'h1);
    chk("flush_stall", {16'b0, b0.stall_cnt}, 32'h1);
    b0.PCwrite = 1'b1; b0.IFIDwrite = 1'b1; b0.redirect = 1'b0;
    step();
    chk("after_pc", b0.imem_addr, 32'h404);
    chk("after_instr", b0.ifid_instr, 32'hA5A5_0400);
    chk("after_valid", {31'b0, b0.ifid_valid}, 32'h1);
    b0.redirect = 1'b1; b0.redirect_target = 32'h102;
    step();
    chk("mis_pc", b0.imem_addr, 32'h100);
    chk("mis_flag", {31'b0, b0.misalign_err}, 32'h1);
    b0.redirect = 1'b0;
    repeat (10) step();
    chk("mis_sticky", {31'b0, b0.misalign_err}, 32'h1);
    chk("mis_run_pc", b0.imem_addr, 32'h128);
    b0.redirect = 1'b1; b0.redirect_target = 32'h200;
    step();
    b0.redirect_target = 32'h300;
    step();
    chk("b2b_pc", b0.imem_addr, 32'h300);
    chk("b2b_valid", {31'b0, b0.ifid_valid}, 32'h0);
    chk("b2b_flush", {16'b0, b0.flush_cnt}, 32'h4);
    b0.redirect = 1'b0; rst0 = 1'b1;
    step();
    chk("rst2_mis", {31'b0, b0.misalign_err}, 32'h0);
    chk("rst2_pc", b0.imem_addr, 32'h0);
    chk("rst2_flush", {16'b0, b0.flush_cnt}, 32'h0);
    rst0 = 1'b0;
    chk("wrap_rst_pc", b1.imem_addr, 32'hFFFF_FFF8);
    rst1 = 1'b0;
    step();
    chk("wrap_pc1", b1.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", b1.imem_addr, 32'h0);
    chk("wrap_pc4", b1.ifid_pc4, 32'h0);
    chk("wrap_mis", {31'b0, b1.misalign_err}, 32'h0);
    b1.PCwrite = 1'b0;
    repeat (7) step();
    chk("sat_at7", {29'b0, b1.stall_cnt}, 32'h7);
    repeat (3) step();
    chk("sat_hold", {29'b0, b1.stall_cnt}, 32'h7);
    chk("sat_pc", b1.imem_addr, 32'h0);
    rst1 = 1'b1; b1.redirect = 1'b1; b1.redirect_target = 32'h42;
    step();
    chk("rstr_pc", b1.imem_addr, 32'hFFFF_FFF8);
    chk("rstr_instr", b1.ifid_instr, 32'h0);
    chk("rstr_pc4", b1.ifid_pc4, 32'h0);
    chk("rstr_valid", {31'b0, b1.ifid_valid}, 32'h0);
    chk("rstr_mis", {31'b0, b1.misalign_err}, 32'h0);
    chk("rstr_stall", {29'b0, b1.stall_cnt}, 32'h0);
    chk("rstr_flush", {29'b0, b1.flush_cnt}, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
